alu_unit: RTL and testbench

Integer execution unit on the issue side of the reservation station.
- Accepts one ready op per issue handshake from the RS and computes it.
- Holds the result until the common data bus (CDB) arbiter grants it, then broadcasts result and ROB tag once; the RS and ROB consume that broadcast.
- Handles RV32I ALU, LUI/AUIPC, JAL/JALR and conditional branches, reporting redirect target and taken flag to the ROB.

---
 rtl/alu_unit_pkg.sv | 38 +++
 rtl/alu_unit_core.sv | 60 ++++++
 rtl/alu_unit.sv | 87 ++++++++
 tb/tb_alu_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// alu_unit_pkg: shared widths, opcode encodings and FSM states for the integer execution unit
package alu_unit_pkg;
  localparam int OP_WIDTH = 6;
  localparam int ROB_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 6'd1;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 6'd2;
  localparam logic [OP_WIDTH-1:0] OP_SLL   = 6'd3;
  localparam logic [OP_WIDTH-1:0] OP_SLT   = 6'd4;
  localparam logic [OP_WIDTH-1:0] OP_SLTU  = 6'd5;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 6'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRL   = 6'd7;
  localparam logic [OP_WIDTH-1:0] OP_SRA   = 6'd8;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 6'd9;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 6'd10;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'd11;
  localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'd12;
  localparam logic [OP_WIDTH-1:0] OP_SLTIU = 6'd13;
  localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'd15;
  localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'd16;
  localparam logic [OP_WIDTH-1:0] OP_SLLI  = 6'd17;
  localparam logic [OP_WIDTH-1:0] OP_SRLI  = 6'd18;
  localparam logic [OP_WIDTH-1:0] OP_SRAI  = 6'd19;
  localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'd20;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = 6'd21;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'd22;
  localparam logic [OP_WIDTH-1:0] OP_JALR  = 6'd23;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'd24;
  localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'd25;
  localparam logic [OP_WIDTH-1:0] OP_BLT   = 6'd26;
  localparam logic [OP_WIDTH-1:0] OP_BGE   = 6'd27;
  localparam logic [OP_WIDTH-1:0] OP_BLTU  = 6'd28;
  localparam logic [OP_WIDTH-1:0] OP_BGEU  = 6'd29;
endpackage

// File: rtl/alu_unit_core.sv
// alu_core: combinational RV32I op evaluation (op, vj, vk, imm, pc) -> (result, jump, target)
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] vj,
  input  logic [DATA_WIDTH-1:0] vk,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  jump,
  output logic [DATA_WIDTH-1:0] target
);
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] pc_imm;
  logic [DATA_WIDTH-1:0] link;
  logic [4:0] sh;
  assign b = (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI}) ? imm : vk;
  assign sh = b[4:0];
  assign pc_imm = pc + imm;
  assign link = pc + DATA_WIDTH'(4);
  always_comb begin
    result = '0;
    jump = FALSE;
    target = '0;
    case (op)
      OP_ADD, OP_ADDI:   result = vj + b;
      OP_SUB:            result = vj - vk;
      OP_SLL, OP_SLLI:   result = vj << sh;
      OP_SRL, OP_SRLI:   result = vj >> sh;
      OP_SRA, OP_SRAI:   result = $unsigned($signed(vj) >>> sh);
      OP_SLT, OP_SLTI:   result = DATA_WIDTH'($signed(vj) < $signed(b));
      OP_SLTU, OP_SLTIU: result = DATA_WIDTH'(vj < b);
      OP_XOR, OP_XORI:   result = vj ^ b;
      OP_OR, OP_ORI:     result = vj | b;
      OP_AND, OP_ANDI:   result = vj & b;
      OP_LUI:            result = imm;
      OP_AUIPC:          result = pc_imm;
      OP_JAL: begin
        result = link;
        jump = TRUE;
        target = pc_imm;
      end
      OP_JALR: begin
        result = link;
        jump = TRUE;
        target = (vj + imm) & ~DATA_WIDTH'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        target = pc_imm;
        jump = op == OP_BEQ  ? vj == vk :
               op == OP_BNE  ? vj != vk :
               op == OP_BLT  ? $signed(vj) < $signed(vk) :
               op == OP_BGE  ? $signed(vj) >= $signed(vk) :
               op == OP_BLTU ? vj < vk : vj >= vk;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: RS issue -> one-cycle exec -> hold until CDB grant -> single broadcast of result/tag/redirect
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  rdy_rs_in,
  input  logic [OP_WIDTH-1:0]   opcode_rs_in,
  input  logic [DATA_WIDTH-1:0] vj_rs_in,
  input  logic [DATA_WIDTH-1:0] vk_rs_in,
  input  logic [DATA_WIDTH-1:0] imm_rs_in,
  input  logic [DATA_WIDTH-1:0] pc_rs_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_rs_in,
  output logic                  idle_rs_out,
  output logic                  req_cdb_out,
  input  logic                  grant_cdb_in,
  output logic                  rdy_cdb_out,
  output logic [DATA_WIDTH-1:0] result_cdb_out,
  output logic [ROB_WIDTH-1:0]  rob_id_cdb_out,
  output logic                  jump_cdb_out,
  output logic [DATA_WIDTH-1:0] target_cdb_out
);
  state_t state;
  logic [OP_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0] vj_q, vk_q, imm_q, pc_q;
  logic [ROB_WIDTH-1:0] tag_q;
  logic [DATA_WIDTH-1:0] result, target;
  logic jump;
  alu_core u_core (
    .op(op_q), .vj(vj_q), .vk(vk_q), .imm(imm_q), .pc(pc_q),
    .result(result), .jump(jump), .target(target)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      idle_rs_out <= TRUE;
      req_cdb_out <= FALSE;
      rdy_cdb_out <= FALSE;
      result_cdb_out <= '0;
      rob_id_cdb_out <= '0;
      jump_cdb_out <= FALSE;
      target_cdb_out <= '0;
      op_q <= '0;
      vj_q <= '0;
      vk_q <= '0;
      imm_q <= '0;
      pc_q <= '0;
      tag_q <= '0;
    end else if (clear_in) begin
      state <= IDLE;
      idle_rs_out <= TRUE;
      req_cdb_out <= FALSE;
      rdy_cdb_out <= FALSE;
    end else if (rdy_in) begin
      rdy_cdb_out <= FALSE;
      case (state)
        IDLE: if (rdy_rs_in && idle_rs_out) begin
          op_q <= opcode_rs_in;
          vj_q <= vj_rs_in;
          vk_q <= vk_rs_in;
          imm_q <= imm_rs_in;
          pc_q <= pc_rs_in;
          tag_q <= rob_id_rs_in;
          idle_rs_out <= FALSE;
          state <= EXEC;
        end
        EXEC: begin
          result_cdb_out <= result;
          jump_cdb_out <= jump;
          target_cdb_out <= target;
          rob_id_cdb_out <= tag_q;
          req_cdb_out <= TRUE;
          state <= WB;
        end
        WB: if (grant_cdb_in) begin
          req_cdb_out <= FALSE;
          rdy_cdb_out <= TRUE;
          idle_rs_out <= TRUE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with scoreboard queue checked by a CDB broadcast monitor
module tb_alu_unit;
  import alu_unit_pkg::*;
  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        jump;
    logic [31:0] target;
  } exp_t;
  logic clk_in = 0, rst_in = 1, rdy_in = 1, clear_in = 0, rdy_rs_in = 0, grant_cdb_in = 1;
  logic [OP_WIDTH-1:0] opcode_rs_in = '0;
  logic [31:0] vj_rs_in = '0, vk_rs_in = '0, imm_rs_in = '0, pc_rs_in = '0;
  logic [3:0] rob_id_rs_in = '0;
  logic idle_rs_out, req_cdb_out, rdy_cdb_out, jump_cdb_out;
  logic [31:0] result_cdb_out, target_cdb_out;
  logic [3:0] rob_id_cdb_out;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  alu_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .rdy_rs_in(rdy_rs_in), .opcode_rs_in(opcode_rs_in), .vj_rs_in(vj_rs_in),
    .vk_rs_in(vk_rs_in), .imm_rs_in(imm_rs_in), .pc_rs_in(pc_rs_in),
    .rob_id_rs_in(rob_id_rs_in), .idle_rs_out(idle_rs_out), .req_cdb_out(req_cdb_out),
    .grant_cdb_in(grant_cdb_in), .rdy_cdb_out(rdy_cdb_out), .result_cdb_out(result_cdb_out),
    .rob_id_cdb_out(rob_id_cdb_out), .jump_cdb_out(jump_cdb_out), .target_cdb_out(target_cdb_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (rdy_cdb_out === 1'b1) begin
      if (sb.size() == 0) chk("unexpected broadcast", 32'(rdy_cdb_out), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb result", result_cdb_out, e.result);
        chk("cdb tag", 32'(rob_id_cdb_out), 32'(e.tag));
        chk("cdb jump", 32'(jump_cdb_out), 32'(e.jump));
        chk("cdb target", target_cdb_out, e.target);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    opcode_rs_in = op;
    vj_rs_in = vj;
    vk_rs_in = vk;
    imm_rs_in = imm;
    pc_rs_in = pc;
    rob_id_rs_in = tag;
    rdy_rs_in = 1;
    tick();
    rdy_rs_in = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 10 && idle_rs_out !== 1'b1; k++) tick();
    if (idle_rs_out !== 1'b1) chk({name, " idle timeout"}, 32'(idle_rs_out), 32'd1);
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                       input logic [31:0] r, input logic j, input logic [31:0] t);
    sb.push_back('{result: r, tag: tag, jump: j, target: t});
    issue(op, vj, vk, imm, pc, tag);
    wait_idle("op");
  endtask

  initial begin
    tick();
    tick();
    rst_in = 0;
    chk("reset idle", 32'(idle_rs_out), 32'd1);
    chk("reset req", 32'(req_cdb_out), 32'd0);
    chk("reset rdy", 32'(rdy_cdb_out), 32'd0);
    chk("reset result", result_cdb_out, 32'd0);
    chk("reset target", target_cdb_out, 32'd0);
    // exact latency with grant held
    sb.push_back('{result: 32'd12, tag: 4'd3, jump: 1'b0, target: 32'd0});
    issue(OP_ADD, 32'd7, 32'd5, 32'd0, 32'd0, 4'd3);
    chk("lat c1 idle", 32'(idle_rs_out), 32'd0);
    chk("lat c1 req", 32'(req_cdb_out), 32'd0);
    tick();
    chk("lat c2 req", 32'(req_cdb_out), 32'd1);
    chk("lat c2 rdy", 32'(rdy_cdb_out), 32'd0);
    tick();
    chk("lat c3 rdy", 32'(rdy_cdb_out), 32'd1);
    chk("lat c3 idle", 32'(idle_rs_out), 32'd1);
    chk("lat c3 req", 32'(req_cdb_out), 32'd0);
    tick();
    chk("pulse width", 32'(rdy_cdb_out), 32'd0);
    do_op(OP_SRA,   32'h80000000, 32'h24,       32'd0,        32'd0,      4'd4, 32'hF8000000, 1'b0, 32'd0);
    do_op(OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,      4'd5, 32'd1,        1'b0, 32'd0);
    do_op(OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,      4'd6, 32'd0,        1'b0, 32'd0);
    do_op(OP_SLTIU, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,      4'd7, 32'd1,        1'b0, 32'd0);
    do_op(OP_SUB,   32'd0,        32'd1,        32'd0,        32'd0,      4'd8, 32'hFFFFFFFF, 1'b0, 32'd0);
    do_op(OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'd0,      4'd9, 32'h12345000, 1'b0, 32'd0);
    do_op(OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000,   4'd10, 32'h3000,    1'b0, 32'd0);
    do_op(OP_JALR,  32'h205,      32'd0,        32'd2,        32'h100,    4'd11, 32'h104,     1'b1, 32'h206);
    do_op(OP_BNE,   32'd9,        32'd9,        32'hFFFFFFF8, 32'h40,     4'd12, 32'd0,       1'b0, 32'h38);
    do_op(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,     4'd13, 32'd0,       1'b1, 32'h90);
    do_op(OP_BGEU,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h80,     4'd14, 32'd0,       1'b1, 32'h90);
    do_op(6'h3F,    32'd3,        32'd4,        32'd5,        32'd6,      4'd15, 32'd0,       1'b0, 32'd0);
    // grant withheld in WB; a stray issue must be ignored
    grant_cdb_in = 0;
    sb.push_back('{result: 32'h30, tag: 4'd2, jump: 1'b0, target: 32'd0});
    issue(OP_OR, 32'h10, 32'h20, 32'd0, 32'd0, 4'd2);
    tick();
    opcode_rs_in = OP_ADD;
    vj_rs_in = 32'd99;
    rob_id_rs_in = 4'd1;
    rdy_rs_in = 1;
    for (int i = 0; i < 5; i++) begin
      chk("hold req", 32'(req_cdb_out), 32'd1);
      chk("hold rdy", 32'(rdy_cdb_out), 32'd0);
      chk("hold idle", 32'(idle_rs_out), 32'd0);
      tick();
    end
    rdy_rs_in = 0;
    grant_cdb_in = 1;
    tick();
    chk("grant rdy", 32'(rdy_cdb_out), 32'd1);
    repeat (3) tick();
    // clear in EXEC
    issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd5);
    clear_in = 1;
    tick();
    clear_in = 0;
    chk("clr exec idle", 32'(idle_rs_out), 32'd1);
    chk("clr exec req", 32'(req_cdb_out), 32'd0);
    repeat (4) tick();
    // clear in WB coinciding with grant
    grant_cdb_in = 0;
    issue(OP_ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd6);
    tick();
    grant_cdb_in = 1;
    clear_in = 1;
    tick();
    clear_in = 0;
    chk("clr wb idle", 32'(idle_rs_out), 32'd1);
    chk("clr wb rdy", 32'(rdy_cdb_out), 32'd0);
    chk("clr wb req", 32'(req_cdb_out), 32'd0);
    repeat (3) tick();
    do_op(OP_ADD, 32'd100, 32'd23, 32'd0, 32'd0, 4'd7, 32'd123, 1'b0, 32'd0);
    // rdy_in low during WB with grant asserted
    grant_cdb_in = 0;
    sb.push_back('{result: 32'h0F, tag: 4'd8, jump: 1'b0, target: 32'd0});
    issue(OP_XOR, 32'hFF, 32'hF0, 32'd0, 32'd0, 4'd8);
    tick();
    rdy_in = 0;
    grant_cdb_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze rdy", 32'(rdy_cdb_out), 32'd0);
      chk("freeze req", 32'(req_cdb_out), 32'd1);
    end
    rdy_in = 1;
    tick();
    chk("resume rdy", 32'(rdy_cdb_out), 32'd1);
    tick();
    chk("resume single", 32'(rdy_cdb_out), 32'd0);
    do_op(OP_JAL, 32'd0, 32'd0, 32'h10, 32'h200, 4'd9, 32'h204, 1'b1, 32'h210);
    // reset mid-EXEC
    issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd10);
    rst_in = 1;
    tick();
    rst_in = 0;
    chk("rst idle", 32'(idle_rs_out), 32'd1);
    chk("rst req", 32'(req_cdb_out), 32'd0);
    chk("rst rdy", 32'(rdy_cdb_out), 32'd0);
    chk("rst jump", 32'(jump_cdb_out), 32'd0);
    chk("rst result", result_cdb_out, 32'd0);
    chk("rst tag", 32'(rob_id_cdb_out), 32'd0);
    chk("rst target", target_cdb_out, 32'd0);
    repeat (4) tick();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
